// File: rtl/gf2_poly_divider.sv
// gf2_poly_divider
// Bit-serial carry-less (GF(2)) polynomial long divider. Divides a (2N-1)-bit
// product-width dividend by an N-bit divisor, one dividend bit per clock, MSB
// first, so that dividend = quotient * divisor XOR remainder with
// deg(remainder) < deg(divisor).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      request, accepted only while idle
//   dividend   2N-1 bit dividend (bit i = x^i), sampled on an accepted start
//   divisor    N bit divisor, sampled on an accepted start
//   busy       high whenever a division is in flight or completing
//   done       one-cycle pulse, results valid
//   div_err    set with done when the divisor is zero
//   quotient   2N-1 bit quotient, held until the next result
//   remainder  N-1 bit remainder, held until the next result

module gf2_poly_divider #(
   parameter int unsigned N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [2*N-2:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           busy,
   output logic           done,
   output logic           div_err,
   output logic [2*N-2:0] quotient,
   output logic [N-2:0]   remainder
);

   localparam int unsigned DW  = 2 * N - 1;
   localparam int unsigned KW  = $clog2(DW);
   localparam int unsigned DGW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e r_state;
   state_e w_state_next;

   logic [DW-1:0]  r_dvd;        // dividend shift register, MSB consumed first
   logic [N-2:0]   r_div;        // divisor bits below the leading term
   logic [DGW-1:0] r_dg;         // degree of the divisor
   logic [N-2:0]   r_rem;        // partial remainder
   logic [DW-1:0]  r_quo;        // quotient being assembled
   logic [KW-1:0]  r_k;          // index of the dividend bit being consumed
   logic [DW-1:0]  r_quotient;
   logic [N-2:0]   r_remainder;
   logic           r_div_err;

   logic           w_accept;
   logic           w_div_zero;
   logic [DGW-1:0] w_dg;
   logic [N-1:0]   w_shift;
   logic           w_qbit;
   logic [N-2:0]   w_rem_next;
   logic [DW-1:0]  w_quo_next;
   logic           w_last;

   assign w_accept   = (r_state == StIdle) && start;
   assign w_div_zero = (divisor == '0);
   assign w_last     = (r_k == '0);

   // Priority encoder: index of the highest set divisor bit.
   always_comb begin
      w_dg = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (divisor[i]) begin
            w_dg = DGW'(i);
         end
      end
   end

   // One long-division step. The divisor's leading term always cancels bit dg
   // of the shifted remainder and everything above dg is zero, so only the
   // divisor bits below its top position ever need to be XORed in.
   assign w_shift    = {r_rem, r_dvd[DW-1]};
   assign w_qbit     = w_shift[r_dg];
   assign w_rem_next = w_shift[N-2:0] ^ (w_qbit ? r_div : '0);
   assign w_quo_next = {r_quo[DW-2:0], w_qbit};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (start) begin
               w_state_next = w_div_zero ? StDone : StRun;
            end
         end
         StRun: begin
            if (w_last) begin
               w_state_next = StDone;
            end
         end
         StDone: w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dvd       <= '0;
         r_div       <= '0;
         r_dg        <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_k         <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_div_err   <= 1'b0;
      end else if (w_accept) begin
         if (w_div_zero) begin
            r_div_err   <= 1'b1;
            r_quotient  <= '0;
            r_remainder <= '0;
         end else begin
            r_div_err <= 1'b0;
            r_dvd     <= dividend;
            r_div     <= divisor[N-2:0];
            r_dg      <= w_dg;
            r_rem     <= '0;
            r_quo     <= '0;
            r_k       <= KW'(DW - 1);
         end
      end else if (r_state == StRun) begin
         r_dvd <= {r_dvd[DW-2:0], 1'b0};
         r_rem <= w_rem_next;
         r_quo <= w_quo_next;
         if (w_last) begin
            // Publish only at the end so outputs stay frozen during RUN.
            r_quotient  <= w_quo_next;
            r_remainder <= w_rem_next;
         end else begin
            r_k <= r_k - KW'(1);
         end
      end
   end

   assign busy      = (r_state != StIdle);
   assign done      = (r_state == StDone);
   assign div_err   = r_div_err;
   assign quotient  = r_quotient;
   assign remainder = r_remainder;

endmodule
